spi_frame_slave: RTL
====================

// Module: spi_frame_slave
// PURPOSE
//  Parametrised SPI slave front end for the accelerator cores (AES and successors).
//  It receives an IN_W-bit command frame from the MCU and pulses start to the core.
//  It then waits for the core's done, captures the OUT_W-bit result and raises rdy.
//  The MCU reads the result out in a second chip-select frame. All logic runs on clk;
//  sck, cs_n and sdi are oversampled, so no sck clock domain exists.
// PARAMETERS
//  IN_W         256  command frame bits, shifted MSB first
//  OUT_W        128  result frame bits, shifted MSB first
//  CPOL         0    sck idle level; sample edge = rising if CPOL==0 else falling
//  SYNC_STAGES  2    synchroniser depth on sck/cs_n/sdi (>=2)
// PORTS
//  clk       in   1      system clock; must be >= 4x sck frequency
//  reset_n   in   1      asynchronous, active-low reset
//  sck       in   1      SPI clock from MCU
//  cs_n      in   1      SPI chip select, active low
//  sdi       in   1      SPI data in (MOSI)
//  sdo       out  1      SPI data out (MISO)
//  in_data   out  IN_W   last complete command frame; held stable until next start
//  start     out  1      one-clk pulse: in_data valid, core may begin
//  done      in   1      core result valid (level, sampled in WAIT_CORE only)
//  result    in   OUT_W  core output; captured on first clk done==1 in WAIT_CORE
//  rdy       out  1      result captured, awaiting read frame (MCU polls this pin)
//  busy      out  1      state != IDLE
//  frame_err out  1      one-clk pulse on an aborted or malformed frame
// BEHAVIOUR
//  Reset: state=IDLE; in_data=0; out_shreg=0; bit count=0.
//   Outputs at reset: sdo=0, start=0, rdy=0, busy=0, frame_err=0.
//   Reset is async at any point, including mid-frame; the partial frame is lost.
//  Sync: each of sck, cs_n and sdi passes through SYNC_STAGES flops.
//   Edges are detected on the synced copies.
//   Sample edge = rising sck (CPOL=0) or falling sck (CPOL=1); launch edge = the opposite.
//  FSM (state held in package enum):
//   IDLE: synced cs_n fall -> SHIFT_IN with cnt=0.
//   SHIFT_IN: on each sample edge, shreg={shreg[IN_W-2:0],sdi_s}; cnt saturates at IN_W+1.
//    cs_n rise with cnt==IN_W: in_data<=shreg; start=1 next clk; -> WAIT_CORE.
//    cs_n rise with cnt!=IN_W: frame_err pulse, in_data unchanged, -> IDLE.
//   WAIT_CORE: done==1: out_shreg<=result; -> RESULT_RDY.
//    cs_n activity and sck edges are ignored; sdo=0.
//   RESULT_RDY: rdy=1.
//    cs_n fall: sdo=out_shreg[OUT_W-1] on the same clk; cnt=0; -> SHIFT_OUT.
//   SHIFT_OUT: on each launch edge after the first sample edge, shift out_shreg left
//    and drive the new MSB; cnt counts sample edges.
//    cs_n rise with cnt>=OUT_W -> IDLE, rdy=0.
//    cs_n rise with cnt<OUT_W: frame_err pulse; -> RESULT_RDY, rdy stays 1,
//     out_shreg reloaded from the captured copy so the read can be retried.
//  sdo is 0 in every state except SHIFT_OUT. It is a plain output, not tri-stated.
//  Latency:
//   synced cs_n rise to start: 1 clk (SYNC_STAGES+1 clk from the pin).
//   done==1 to rdy: 1 clk.
//  Simultaneous sample edge and cs_n rise in the same clk: the edge is counted first.
//  start is never asserted twice for one frame. done is ignored outside WAIT_CORE.
//  Counter width $clog2(max(IN_W,OUT_W)+2).
// STRUCTURE
//  spi_frame_pkg: typedef enum logic [2:0] spi_state_t
//   {IDLE,SHIFT_IN,WAIT_CORE,RESULT_RDY,SHIFT_OUT}; helper function cnt_w(IN_W,OUT_W).
//  Sub-module spi_sync_edge (#(SYNC_STAGES)): synchroniser plus rise/fall pulse outputs.
//   Instantiated for sck and cs_n; sdi uses the synchroniser only.
//  Top level holds the FSM, counter, in/out shift registers and result copy.
// TESTING (clk 100 MHz, sck 10 MHz, default params, stub core returns done 20 clk after start)
//  1 AES vector: shift {pt 3243F6A8885A308D313198A2E0370734, key 2B7E151628AED2A6ABF7158809CF4F3C}
//    -> in_data matches, single start pulse.
//    Stub returns 3925841D02DC09FBDC118597196A0B32 -> rdy=1.
//    128-bit read frame returns the same value; rdy=0 after cs_n rise.
//  2 Short frame: cs_n rises after 100 bits -> frame_err pulse, no start, in_data unchanged, busy=0.
//  3 Interrupted read: cs_n rises after 64 of 128 bits -> frame_err, rdy stays 1.
//    Full re-read returns the complete result from bit 127.
//  4 Traffic in WAIT_CORE: 32 sck toggles under cs_n low before done
//    -> sdo stays 0, no state change, result still correct.
//  5 Reset: reset_n low for 3 clk at bit 150 of an input frame
//    -> all outputs 0 immediately; next full frame works normally.
//  6 CPOL=1 build: vector 1 driven with idle-high sck -> identical in_data and result.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// rtl/spi_frame_pkg.sv - shared state encoding and sizing helper for the SPI frame slave
//   spi_state_t : FSM states of spi_frame_slave
//   cnt_w()     : bit counter width able to hold max(IN_W,OUT_W)+1
package spi_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    WAIT_CORE,
    RESULT_RDY,
    SHIFT_OUT
  } spi_state_t;

  // The counter saturates one past the longest frame so that an overlong
  // frame can be told apart from an exact-length one.
  function automatic int cnt_w(input int in_w, input int out_w);
    int m;
    m = (in_w > out_w) ? in_w : out_w;
    return $clog2(m + 2);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with rise/fall pulse detection
//   clk, reset_n : system clock, async active-low reset
//   din          : asynchronous input pin
//   rise, fall   : one-clk pulses on edges of the synchronised copy
// RESET_VAL should equal the pin's idle level so that reset release does not
// fabricate an edge.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_frame_slave.sv
// rtl/spi_frame_slave.sv - oversampled SPI slave: command frame in, core handshake, result frame out
//   clk, reset_n   : system clock (>= 4x sck), async active-low reset
//   sck, cs_n, sdi : SPI inputs from the MCU (asynchronous to clk)
//   sdo            : SPI data out, 0 outside the read frame
//   in_data, start : received command frame and its one-clk valid pulse
//   done, result   : core completion level and result word
//   rdy            : result captured and waiting to be read
//   busy           : any state other than IDLE
//   frame_err      : one-clk pulse on an aborted/malformed frame
module spi_frame_slave
  import spi_frame_pkg::*;
#(
  parameter int   IN_W        = 256,
  parameter int   OUT_W       = 128,
  parameter logic CPOL        = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sck,
  input  logic             cs_n,
  input  logic             sdi,
  output logic             sdo,
  output logic [IN_W-1:0]  in_data,
  output logic             start,
  input  logic             done,
  input  logic [OUT_W-1:0] result,
  output logic             rdy,
  output logic             busy,
  output logic             frame_err
);

  localparam int CNT_W = cnt_w(IN_W, OUT_W);
  localparam int MAX_W = (IN_W > OUT_W) ? IN_W : OUT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_W + 1);
  localparam logic [CNT_W-1:0] IN_CNT  = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_W);

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic sample, launch;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic sdi_s;

  spi_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [IN_W-1:0]  shreg, shreg_n;
  logic [IN_W-1:0]  in_data_n;
  logic [OUT_W-1:0] out_shreg, out_shreg_n;
  logic [OUT_W-1:0] res_copy, res_copy_n;
  logic start_n, frame_err_n;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sck_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (sck),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (cs_n),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  // sdi has the same depth as sck, so the bit is aligned with its sample edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdi_sync <= '0;
    end else begin
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
    end
  end
  assign sdi_s = sdi_sync[SYNC_STAGES-1];

  assign sample  = CPOL ? sck_fall : sck_rise;
  assign launch  = CPOL ? sck_rise : sck_fall;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      in_data   <= '0;
      out_shreg <= '0;
      res_copy  <= '0;
      start     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      in_data   <= in_data_n;
      out_shreg <= out_shreg_n;
      res_copy  <= res_copy_n;
      start     <= start_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    shreg_n     = shreg;
    in_data_n   = in_data;
    out_shreg_n = out_shreg;
    res_copy_n  = res_copy;
    start_n     = 1'b0;
    frame_err_n = 1'b0;

    case (state)
      IDLE: begin
        if (cs_fall) begin
          cnt_n   = '0;
          state_n = SHIFT_IN;
        end
      end

      SHIFT_IN: begin
        if (sample) begin
          shreg_n = {shreg[IN_W-2:0], sdi_s};
          cnt_n   = cnt_inc;
        end
        // cnt_n/shreg_n already include an edge landing in the same clk.
        if (cs_rise) begin
          if (cnt_n == IN_CNT) begin
            in_data_n = shreg_n;
            start_n   = 1'b1;
            state_n   = WAIT_CORE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = IDLE;
          end
        end
      end

      WAIT_CORE: begin
        if (done) begin
          out_shreg_n = result;
          res_copy_n  = result;
          state_n     = RESULT_RDY;
        end
      end

      RESULT_RDY: begin
        if (cs_fall) begin
          cnt_n   = '0;
          state_n = SHIFT_OUT;
        end
      end

      SHIFT_OUT: begin
        if (sample) begin
          cnt_n = cnt_inc;
        end else if (launch && cnt != '0) begin
          // The MSB is already on sdo at cs_n fall, so only launch edges
          // that follow a sample edge advance the register.
          out_shreg_n = {out_shreg[OUT_W-2:0], 1'b0};
        end
        if (cs_rise) begin
          if (cnt_n >= OUT_CNT) begin
            state_n = IDLE;
          end else begin
            frame_err_n = 1'b1;
            out_shreg_n = res_copy;
            state_n     = RESULT_RDY;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign rdy  = (state == RESULT_RDY) || (state == SHIFT_OUT);
  assign sdo  = (state == SHIFT_OUT) && out_shreg[OUT_W-1];

endmodule
